div_pipe: RTL and testbench

- Parametrised, fully pipelined integer divider for the execution unit; accepts one divide per cycle and returns quotient and remainder together.
- Successor to the fixed 32-bit, 8-stage divider. Adds:
  - configurable width and radix per stage
  - valid/ready handshake with backpressure
  - tag passthrough and flush
  - reset
  - RISC-V-compliant divide-by-zero and overflow results
- Sits between the issue logic and the writeback arbiter.

---
 rtl/div_pipe_if.sv | 46 ++++
 rtl/div_pipe.sv | 132 +++++++++++++
 tb/tb_div_pipe.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pipe_if.sv
// div_pipe_if: operand/result handshake bundle for div_pipe.
// master drives operations and consumes results, slave is the divider.
interface div_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid,
        output is_signed,
        output s,
        output t,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  q,
        input  r,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  is_signed,
        input  s,
        input  t,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output q,
        output r,
        output out_tag
    );
endinterface

// File: rtl/div_pipe.sv
// div_pipe: fully pipelined restoring integer divider, one op per cycle.
// Global stall on output backpressure; RISC-V divide-by-zero/overflow.
module div_pipe #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    div_pipe_if.slave  io
);
    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef struct packed {
        logic [2*WIDTH-1:0] rem;
        logic [WIDTH-1:0]   quo;
        logic [WIDTH-1:0]   tabs;
        logic [WIDTH-1:0]   s;
        logic [TAG_W-1:0]   tag;
        logic               ssign;
        logic               tsign;
        logic               dz;
        logic               ov;
    } op_t;

    logic              stall;
    logic              accept;
    logic [STAGES-1:0] v;
    logic [STAGES:0]   v_chain;
    logic [WIDTH-1:0]  sabs;
    op_t               pre;
    op_t               last;
    op_t               stage_q [STAGES];
    logic [WIDTH-1:0]  q_mag;
    logic [WIDTH-1:0]  r_mag;
    logic              unused_bits;

    assign stall       = v[STAGES-1] && !io.out_ready;
    assign io.in_ready = !flush && !stall;
    assign accept      = io.in_valid && io.in_ready;
    assign v_chain     = {v, accept};

    // Operand preprocessing: signs, magnitudes and special-case flags
    always_comb begin
        pre       = '0;
        pre.ssign = io.is_signed && io.s[WIDTH-1];
        pre.tsign = io.is_signed && io.t[WIDTH-1];
        sabs      = pre.ssign ? -io.s : io.s;
        pre.tabs  = pre.tsign ? -io.t : io.t;
        pre.rem   = {{WIDTH{1'b0}}, sabs};
        pre.quo   = '0;
        pre.s     = io.s;
        pre.tag   = io.in_tag;
        pre.dz    = (io.t == '0);
        pre.ov    = io.is_signed && (io.s == MIN) && (io.t == ONES);
    end

    // Stage valid bits: cleared by reset or flush, frozen during stall
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (!stall) begin
            v <= v_chain[STAGES-1:0];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        op_t                cur;
        op_t                nxt;
        logic [2*WIDTH-1:0] dsh;

        if (k == 0) begin : g_head
            assign cur = pre;
        end else begin : g_body
            assign cur = stage_q[k-1];
        end

        // Restoring compare/subtract steps resolved in this stage
        always_comb begin
            nxt = cur;
            dsh = '0;
            for (int j = 0; j < BITS_PER_STAGE; j++) begin
                dsh = {{WIDTH{1'b0}}, cur.tabs}
                      << (WIDTH - 1 - (k * BITS_PER_STAGE + j));
                if (nxt.rem >= dsh) begin
                    nxt.rem = nxt.rem - dsh;
                    nxt.quo = {nxt.quo[WIDTH-2:0], 1'b1};
                end else begin
                    nxt.quo = {nxt.quo[WIDTH-2:0], 1'b0};
                end
            end
        end

        // Stage data register, held while the output is blocked
        always_ff @(posedge clk) begin
            if (!stall) begin
                stage_q[k] <= nxt;
            end
        end
    end

    assign last           = stage_q[STAGES-1];
    assign io.out_valid   = v[STAGES-1];
    assign unused_bits    = ^{last.rem[2*WIDTH-1:WIDTH], last.tabs};

    // Result fix-up: special cases first, then sign restore; zero when idle
    always_comb begin
        q_mag      = last.quo;
        r_mag      = last.rem[WIDTH-1:0];
        io.q       = '0;
        io.r       = '0;
        io.out_tag = '0;
        if (v[STAGES-1]) begin
            io.out_tag = last.tag;
            if (last.dz) begin
                io.q = ONES;
                io.r = last.s;
            end else if (last.ov) begin
                io.q = MIN;
                io.r = '0;
            end else begin
                io.q = (last.ssign ^ last.tsign) ? -q_mag : q_mag;
                io.r = last.ssign ? -r_mag : r_mag;
            end
        end
    end
endmodule

// File: tb/tb_div_pipe.sv
// tb_div_pipe: self-checking bench for div_pipe at three parameter points
// against an arithmetic reference model.
module tb_div_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        flush;
    int          sel;
    logic        g_iv;
    logic        g_or;
    logic        g_sg;
    logic [63:0] g_s;
    logic [63:0] g_t;
    logic [4:0]  g_tag;
    logic        g_ov;
    logic        g_ir;
    logic [63:0] g_q;
    logic [63:0] g_r;
    logic [4:0]  g_otag;

    int errors = 0;
    int checks = 0;

    div_pipe_if #(.WIDTH(32), .TAG_W(5)) b0 ();
    div_pipe_if #(.WIDTH(16), .TAG_W(5)) b1 ();
    div_pipe_if #(.WIDTH(8),  .TAG_W(5)) b2 ();

    div_pipe #(.WIDTH(32), .BITS_PER_STAGE(4), .TAG_W(5)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush), .io(b0));
    div_pipe #(.WIDTH(16), .BITS_PER_STAGE(2), .TAG_W(5)) dut1 (
        .clk(clk), .rstn(rstn), .flush(flush), .io(b1));
    div_pipe #(.WIDTH(8),  .BITS_PER_STAGE(8), .TAG_W(5)) dut2 (
        .clk(clk), .rstn(rstn), .flush(flush), .io(b2));

    assign b0.in_valid  = (sel == 0) && g_iv;
    assign b0.out_ready = (sel == 0) ? g_or : 1'b1;
    assign b0.is_signed = g_sg;
    assign b0.s         = g_s[31:0];
    assign b0.t         = g_t[31:0];
    assign b0.in_tag    = g_tag;
    assign b1.in_valid  = (sel == 1) && g_iv;
    assign b1.out_ready = (sel == 1) ? g_or : 1'b1;
    assign b1.is_signed = g_sg;
    assign b1.s         = g_s[15:0];
    assign b1.t         = g_t[15:0];
    assign b1.in_tag    = g_tag;
    assign b2.in_valid  = (sel == 2) && g_iv;
    assign b2.out_ready = (sel == 2) ? g_or : 1'b1;
    assign b2.is_signed = g_sg;
    assign b2.s         = g_s[7:0];
    assign b2.t         = g_t[7:0];
    assign b2.in_tag    = g_tag;

    // Route the selected DUT's outputs to width-neutral observation signals
    always_comb begin
        g_ov   = 1'b0;
        g_ir   = 1'b0;
        g_q    = '0;
        g_r    = '0;
        g_otag = '0;
        case (sel)
            0: begin
                g_ov = b0.out_valid; g_ir = b0.in_ready;
                g_q = {32'd0, b0.q}; g_r = {32'd0, b0.r}; g_otag = b0.out_tag;
            end
            1: begin
                g_ov = b1.out_valid; g_ir = b1.in_ready;
                g_q = {48'd0, b1.q}; g_r = {48'd0, b1.r}; g_otag = b1.out_tag;
            end
            default: begin
                g_ov = b2.out_valid; g_ir = b2.in_ready;
                g_q = {56'd0, b2.q}; g_r = {56'd0, b2.r}; g_otag = b2.out_tag;
            end
        endcase
    end

    function automatic int w_of(input int sl);
        return (sl == 0) ? 32 : (sl == 1) ? 16 : 8;
    endfunction

    function automatic int st_of(input int sl);
        return (sl == 2) ? 1 : 8;
    endfunction

    // Reference: truncating division with RISC-V special cases
    task automatic ref_div(input int w, input bit sg,
                           input logic [63:0] s, input logic [63:0] t,
                           output logic [63:0] q, output logic [63:0] r);
        logic [63:0] mask;
        longint      sv;
        longint      tv;
        mask = (64'd1 << w) - 64'd1;
        if (t == 64'd0) begin
            q = mask;
            r = s;
        end else if (sg) begin
            sv = s[w-1] ? longint'(s) - longint'(64'd1 << w) : longint'(s);
            tv = t[w-1] ? longint'(t) - longint'(64'd1 << w) : longint'(t);
            if (sv == -(longint'(1) << (w - 1)) && tv == -1) begin
                q = 64'd1 << (w - 1);
                r = 64'd0;
            end else begin
                q = 64'(sv / tv) & mask;
                r = 64'(sv % tv) & mask;
            end
        end else begin
            q = s / t;
            r = s % t;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        g_iv  = 1'b0;
        g_or  = 1'b1;
        flush = 1'b0;
        rstn  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Issue one op and wait for its result; lat counts cycles after accept
    task automatic run_one(input bit sg, input logic [63:0] s,
                           input logic [63:0] t, input logic [4:0] tag,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic [4:0] otag, output int lat);
        @(negedge clk);
        g_iv = 1'b1; g_sg = sg; g_s = s; g_t = t; g_tag = tag; g_or = 1'b1;
        @(negedge clk);
        g_iv = 1'b0;
        lat  = -1;
        q    = 'x;
        r    = 'x;
        otag = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (lat < 0) begin
                #1;
                if (g_ov) begin
                    lat = k; q = g_q; r = g_r; otag = g_otag;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        g_iv = 1'b1; g_s = 64'd5; g_t = 64'd1; g_tag = 5'd3;
        rstn = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (g_ov !== 1'b0)
            $display("FAIL reset_out_valid got %b want 0", g_ov);
        if (g_ov !== 1'b0) errors++;
        checks++;
        if (g_q !== 64'd0 || g_r !== 64'd0 || g_otag !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got q=%h r=%h tag=%h want 0",
                     g_q, g_r, g_otag);
        end
        g_iv = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] q, r;
        logic [4:0]  ot;
        int          lat;
        sel = 0;
        run_one(1'b0, 64'd100, 64'd7, 5'd9, q, r, ot, lat);
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL basic_latency got %0d want 8", lat);
        end
        checks++;
        if (q !== 64'd14) begin
            errors++; $display("FAIL basic_q got %h want 14", q);
        end
        checks++;
        if (r !== 64'd2) begin
            errors++; $display("FAIL basic_r got %h want 2", r);
        end
        checks++;
        if (ot !== 5'd9) begin
            errors++; $display("FAIL basic_tag got %h want 9", ot);
        end
    endtask

    typedef struct {
        bit          sg;
        logic [63:0] s;
        logic [63:0] t;
        logic [63:0] q;
        logic [63:0] r;
    } vec_t;

    task automatic test_directed();
        vec_t        vt [9];
        logic [63:0] q, r;
        logic [4:0]  ot;
        int          lat;
        sel = 0;
        vt[0] = '{1'b1, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 64'hFFFFFFFF};
        vt[1] = '{1'b1, 64'h7, 64'hFFFFFFFE, 64'hFFFFFFFD, 64'h1};
        vt[2] = '{1'b1, 64'hFFFFFFF9, 64'hFFFFFFFE, 64'h3, 64'hFFFFFFFF};
        vt[3] = '{1'b0, 64'hFFFFFFF9, 64'h2, 64'h7FFFFFFC, 64'h1};
        vt[4] = '{1'b0, 64'h1234, 64'h0, 64'hFFFFFFFF, 64'h1234};
        vt[5] = '{1'b1, 64'h1234, 64'h0, 64'hFFFFFFFF, 64'h1234};
        vt[6] = '{1'b1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 64'h0};
        vt[7] = '{1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h0, 64'h80000000};
        vt[8] = '{1'b1, 64'hFFFFEDCC, 64'h0, 64'hFFFFFFFF, 64'hFFFFEDCC};
        for (int i = 0; i < 9; i++) begin
            run_one(vt[i].sg, vt[i].s, vt[i].t, 5'(i), q, r, ot, lat);
            checks++;
            if (q !== vt[i].q || r !== vt[i].r || lat !== 8) begin
                errors++;
                $display("FAIL dir[%0d] got q=%h r=%h lat=%0d want q=%h r=%h lat=8",
                         i, q, r, lat, vt[i].q, vt[i].r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] op_s [12];
        logic [63:0] op_t [12];
        bit          op_sg [12];
        logic [63:0] res_q [12];
        logic [63:0] res_r [12];
        logic [4:0]  res_t [12];
        logic [63:0] eq, er;
        logic [63:0] hq, hr;
        logic [4:0]  ht;
        int          sent, got, extra, drop_left;
        bit          dropped;
        sel = 0;
        for (int i = 0; i < 12; i++) begin
            op_s[i]  = {32'd0, $urandom};
            op_t[i]  = {32'd0, $urandom} >> $urandom_range(31);
            op_sg[i] = 1'($urandom_range(1));
        end
        sent = 0; got = 0; extra = 0; drop_left = 0; dropped = 0;
        hq = '0; hr = '0; ht = '0;
        for (int c = 0; c < 100; c++) begin
            if (got < 12) begin
                @(negedge clk);
                if (sent < 12) begin
                    g_iv = 1'b1; g_sg = op_sg[sent];
                    g_s = op_s[sent]; g_t = op_t[sent]; g_tag = sent[4:0];
                end else begin
                    g_iv = 1'b0;
                end
                if (g_ov && !dropped) begin
                    dropped = 1; drop_left = 3;
                    hq = g_q; hr = g_r; ht = g_otag;
                end
                g_or = (drop_left == 0);
                #1;
                if (drop_left > 0) begin
                    checks++;
                    if (g_ir !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_in_ready got %b want 0", g_ir);
                    end
                    checks++;
                    if (g_ov !== 1'b1 || g_q !== hq || g_r !== hr || g_otag !== ht) begin
                        errors++;
                        $display("FAIL b2b_hold got v=%b q=%h r=%h tag=%h want v=1 q=%h r=%h tag=%h",
                                 g_ov, g_q, g_r, g_otag, hq, hr, ht);
                    end
                    drop_left--;
                end
                if (g_ov && g_or) begin
                    res_q[got] = g_q; res_r[got] = g_r; res_t[got] = g_otag;
                    got++;
                end
                if (g_iv && g_ir) sent++;
            end
        end
        g_iv = 1'b0; g_or = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (g_ov) extra++;
        end
        checks++;
        if (got !== 12 || extra !== 0) begin
            errors++;
            $display("FAIL b2b_count got %0d (+%0d extra) want 12", got, extra);
        end
        for (int i = 0; i < 12; i++) begin
            if (i < got) begin
                ref_div(32, op_sg[i], op_s[i], op_t[i], eq, er);
                checks++;
                if (res_t[i] !== 5'(i) || res_q[i] !== eq || res_r[i] !== er) begin
                    errors++;
                    $display("FAIL b2b[%0d] got tag=%0d q=%h r=%h want tag=%0d q=%h r=%h",
                             i, res_t[i], res_q[i], res_r[i], i, eq, er);
                end
            end
        end
    endtask

    // Kill in-flight ops with flush (use_reset=0) or reset (use_reset=1)
    task automatic test_kill(input bit use_reset);
        logic [63:0] q, r;
        logic [4:0]  ot;
        int          lat, stale;
        sel = 0;
        g_or = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            g_iv = 1'b1; g_sg = 1'b0;
            g_s = {32'd0, $urandom}; g_t = 64'd3; g_tag = 5'(i + 20);
        end
        @(negedge clk);
        g_s = 64'd77; g_t = 64'd7; g_tag = 5'd31;
        if (use_reset) rstn = 1'b0;
        else flush = 1'b1;
        #1;
        if (!use_reset) begin
            checks++;
            if (g_ir !== 1'b0) begin
                errors++;
                $display("FAIL flush_in_ready got %b want 0", g_ir);
            end
        end
        @(negedge clk);
        rstn = 1'b1; flush = 1'b0; g_iv = 1'b0;
        #1;
        checks++;
        if (g_ov !== 1'b0 || g_q !== 64'd0 || g_r !== 64'd0 || g_otag !== 5'd0) begin
            errors++;
            $display("FAIL kill%0d_after got v=%b q=%h r=%h tag=%h want all 0",
                     use_reset, g_ov, g_q, g_r, g_otag);
        end
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (g_ov) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL kill%0d_stale got %0d results want 0", use_reset, stale);
        end
        run_one(1'b0, 64'd1000, 64'd33, 5'd17, q, r, ot, lat);
        checks++;
        if (lat !== 8 || q !== 64'd30 || r !== 64'd10 || ot !== 5'd17) begin
            errors++;
            $display("FAIL kill%0d_next got lat=%0d q=%h r=%h tag=%0d want lat=8 q=1e r=a tag=17",
                     use_reset, lat, q, r, ot);
        end
    endtask

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic [4:0]  tag;
        int          cyc;
        int          stl;
    } exp_t;

    task automatic test_random(input int sl, input int n);
        exp_t        sb [$];
        exp_t        e;
        logic [63:0] mask, s, t, eq, er;
        int          w, st, sent, done, cyc, stalls, lat, pick;
        bit          sg;
        sel = sl;
        do_reset();
        w = w_of(sl); st = st_of(sl);
        mask = (64'd1 << w) - 64'd1;
        sent = 0; done = 0; cyc = 0; stalls = 0;
        for (int c = 0; c < n * 8 + 200; c++) begin
            if (done < n) begin
                @(negedge clk);
                if (sent < n && $urandom_range(3) != 0) begin
                    sg = 1'($urandom_range(1));
                    s = {$urandom, $urandom} & mask;
                    t = ({$urandom, $urandom} >> $urandom_range(63)) & mask;
                    pick = $urandom_range(7);
                    if (pick == 0) t = 64'd0;
                    if (pick == 1) t = mask;
                    if (pick == 2) s = 64'd1 << (w - 1);
                    if (pick == 3) t = 64'($urandom_range(15));
                    if (pick == 4) begin s = 64'd1 << (w - 1); t = mask; end
                    g_iv = 1'b1; g_sg = sg; g_s = s; g_t = t;
                    g_tag = 5'($urandom_range(31));
                end else begin
                    g_iv = 1'b0;
                end
                g_or = ($urandom_range(3) != 0);
                #1;
                if (!g_ov) begin
                    checks++;
                    if (g_q !== 64'd0 || g_r !== 64'd0 || g_otag !== 5'd0) begin
                        errors++;
                        $display("FAIL rand%0d_gating got q=%h r=%h tag=%h want 0",
                                 sl, g_q, g_r, g_otag);
                    end
                end
                if (g_ov && g_or) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rand%0d_spurious got result q=%h want none",
                                 sl, g_q);
                    end else begin
                        e = sb.pop_front();
                        if (g_q !== e.q || g_r !== e.r || g_otag !== e.tag) begin
                            errors++;
                            $display("FAIL rand%0d_data got q=%h r=%h tag=%h want q=%h r=%h tag=%h",
                                     sl, g_q, g_r, g_otag, e.q, e.r, e.tag);
                        end
                        lat = cyc - e.cyc - (stalls - e.stl);
                        checks++;
                        if (lat !== st) begin
                            errors++;
                            $display("FAIL rand%0d_latency got %0d want %0d",
                                     sl, lat, st);
                        end
                    end
                    done++;
                end
                if (g_ov && !g_or) stalls++;
                if (g_iv && g_ir) begin
                    ref_div(w, g_sg, g_s, g_t, eq, er);
                    sb.push_back('{eq, er, g_tag, cyc, stalls});
                    sent++;
                end
                cyc++;
            end
        end
        g_iv = 1'b0; g_or = 1'b1;
        checks++;
        if (done !== n || sb.size() !== 0) begin
            errors++;
            $display("FAIL rand%0d_count got %0d done %0d pending want %0d done",
                     sl, done, sb.size(), n);
        end
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0; sel = 0;
        g_iv = 1'b0; g_or = 1'b1; g_sg = 1'b0;
        g_s = '0; g_t = '0; g_tag = '0;
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_kill(1'b0);
        test_kill(1'b1);
        test_random(0, 2000);
        test_random(1, 10000);
        test_random(2, 10000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
